// File: rtl/decode_writeback.sv
// Y86-64 decode / write-back stage.
// Decodes register IDs from the D pipeline register, reads operands from the
// 15-entry register file with forwarding from E, M and W, and commits W-stage
// results into the register file on the rising clock edge.
module decode_writeback #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] SP_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        d_dstE,
    output logic [3:0]        d_dstM,
    output logic [DATA_W-1:0] d_valA,
    output logic [DATA_W-1:0] d_valB,
    output logic [3:0]        d_ifun,
    output logic [DATA_W-1:0] d_valC
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // Architectural register file, IDs 0..14 (ID 15 is RNONE and never stored).
    logic [DATA_W-1:0] regs_q [0:14];
    logic [DATA_W-1:0] regs_d [0:14];

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;

    assign d_ifun = D_ifun;
    assign d_valC = D_valC;

    // Forwarding chain: youngest producer first; RNONE never matches.
    function automatic logic [DATA_W-1:0] forward(input logic [3:0]        src,
                                                  input logic [DATA_W-1:0] rf_val);
        logic [DATA_W-1:0] val;
        if (src == RNONE)                       val = '0;
        else if (e_dstE == src)                 val = e_valE;
        else if (M_dstM == src)                 val = m_valM;
        else if (M_dstE == src)                 val = M_valE;
        else if (W_dstM == src)                 val = W_valM;
        else if (W_dstE == src)                 val = W_valE;
        else                                    val = rf_val;
        return val;
    endfunction

    // Register ID decode from the instruction code.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
            I_IRMOVQ: begin d_dstE = D_rB; end
            I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
            I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
            I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            I_CALL:   begin d_srcB = RSP;  d_dstE = RSP; end
            I_RET:    begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP; end
            I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP;  d_dstE = RSP; end
            I_POPQ:   begin d_srcA = RSP;  d_srcB = RSP;  d_dstE = RSP; d_dstM = D_rA; end
            default:  ;
        endcase
    end

    // Operand read: raw register-file value, then forwarding and valP selection.
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        if (d_srcA != RNONE) rf_a = regs_q[d_srcA];
        if (d_srcB != RNONE) rf_b = regs_q[d_srcB];
        if (D_icode == I_JXX || D_icode == I_CALL) d_valA = D_valP;
        else                                       d_valA = forward(d_srcA, rf_a);
        d_valB = forward(d_srcB, rf_b);
    end

    // Next register-file state: E port first, M port second so M wins a collision.
    always_comb begin
        regs_d = regs_q;
        if (W_dstE != RNONE) regs_d[W_dstE] = W_valE;
        if (W_dstM != RNONE) regs_d[W_dstM] = W_valM;
    end

    // Register-file state; reset loads %rsp with SP_RESET and clears the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is architectural state with a defined reset value, so it
            // is built from resettable flops rather than an unreset RAM macro.
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == int'(RSP)) ? SP_RESET : '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples
            // pre-edge values regardless of statement order.
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: a decode table, hand sequences for
// the multi-cycle corners, and randomized traffic against a reference model.
module tb_decode_writeback;

    localparam logic [63:0] SP_INIT = 64'h100;
    localparam logic [3:0]  F       = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM, d_ifun;
    logic [63:0] d_valA, d_valB, d_valC;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference register file (index 15 unused).
    logic [63:0] m_rf [16];

    decode_writeback #(.DATA_W(64), .SP_RESET(SP_INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_valA(d_valA), .d_valB(d_valB), .d_ifun(d_ifun), .d_valC(d_valC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [3:0]  rA;
        logic [3:0]  rB;
        logic [63:0] valP;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [63:0] valA;
        logic [63:0] valB;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 64'h0;
        m_rf[4] = SP_INIT;
    endtask

    // One rising edge; the model commits what the W stage presents at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (W_dstE != F) m_rf[W_dstE] = W_valE;
            if (W_dstM != F) m_rf[W_dstM] = W_valM;
        end else begin
            model_reset();
        end
        #2;
    endtask

    task automatic clear_fwd();
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
        e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
        D_icode = ic; D_rA = ra; D_rB = rb;
    endtask

    // Reference decode, written as set membership over the instruction codes.
    function automatic void ref_ids(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                    output logic [3:0] sa, output logic [3:0] sb,
                                    output logic [3:0] de, output logic [3:0] dm);
        sa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (ic inside {4'h9, 4'hB}) ? 4'h4 : F;
        sb = (ic inside {4'h4, 4'h5, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : F;
        de = (ic inside {4'h2, 4'h3, 4'h6}) ? rb : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : F;
        dm = (ic inside {4'h5, 4'hB}) ? ra : F;
    endfunction

    // Reference operand: scan producers youngest-to-oldest, else the model file.
    function automatic logic [63:0] ref_operand(input logic [3:0] src);
        logic [3:0]  dsts [5];
        logic [63:0] vals [5];
        dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        if (src == F) return 64'h0;
        for (int k = 0; k < 5; k++) begin
            if (dsts[k] == src) return vals[k];
        end
        return m_rf[src];
    endfunction

    task automatic check_model(input string tag);
        logic [3:0] sa, sb, de, dm;
        logic [63:0] va;
        ref_ids(D_icode, D_rA, D_rB, sa, sb, de, dm);
        va = (D_icode inside {4'h7, 4'h8}) ? D_valP : ref_operand(sa);
        check({tag, ".srcA"}, 64'(d_srcA), 64'(sa));
        check({tag, ".srcB"}, 64'(d_srcB), 64'(sb));
        check({tag, ".dstE"}, 64'(d_dstE), 64'(de));
        check({tag, ".dstM"}, 64'(d_dstM), 64'(dm));
        check({tag, ".valA"}, d_valA, va);
        check({tag, ".valB"}, d_valB, ref_operand(sb));
        check({tag, ".ifun"}, 64'(d_ifun), 64'(D_ifun));
        check({tag, ".valC"}, d_valC, D_valC);
    endtask

    function automatic logic [3:0] rand_reg();
        int unsigned v;
        v = $urandom_range(0, 11);
        if (v >= 9) return F;
        if (v == 8) return 4'($urandom_range(0, 14));
        return 4'(v);
    endfunction

    initial begin
        // Expected table assuming reset register state (reg4 = 0x100, others 0), no forwarding.
        //          icode  rA     rB     valP         srcA   srcB   dstE   dstM   valA         valB
        vecs[0]  = '{4'h0, 4'h1, 4'h2, 64'h0,       F,     F,     F,     F,     64'h0,       64'h0};
        vecs[1]  = '{4'h1, 4'h1, 4'h2, 64'h0,       F,     F,     F,     F,     64'h0,       64'h0};
        vecs[2]  = '{4'h2, 4'h3, 4'h5, 64'h0,       4'h3,  F,     4'h5,  F,     64'h0,       64'h0};
        vecs[3]  = '{4'h3, F,    4'h6, 64'h0,       F,     F,     4'h6,  F,     64'h0,       64'h0};
        vecs[4]  = '{4'h4, 4'h4, 4'h4, 64'h0,       4'h4,  4'h4,  F,     F,     64'h100,     64'h100};
        vecs[5]  = '{4'h5, 4'h7, 4'h4, 64'h0,       F,     4'h4,  F,     4'h7,  64'h0,       64'h100};
        vecs[6]  = '{4'h6, 4'h4, 4'h2, 64'h0,       4'h4,  4'h2,  4'h2,  F,     64'h100,     64'h0};
        vecs[7]  = '{4'h7, F,    F,    64'h1234,    F,     F,     F,     F,     64'h1234,    64'h0};
        vecs[8]  = '{4'h8, F,    F,    64'h2000,    F,     4'h4,  4'h4,  F,     64'h2000,    64'h100};
        vecs[9]  = '{4'h9, F,    F,    64'h0,       4'h4,  4'h4,  4'h4,  F,     64'h100,     64'h100};
        vecs[10] = '{4'hA, 4'h2, F,    64'h0,       4'h2,  4'h4,  4'h4,  F,     64'h0,       64'h100};
        vecs[11] = '{4'hB, 4'h3, F,    64'h0,       4'h4,  4'h4,  4'h4,  4'h3,  64'h100,     64'h100};
        vecs[12] = '{4'hC, 4'h4, 4'h4, 64'h77,      F,     F,     F,     F,     64'h0,       64'h0};
        vecs[13] = '{4'hD, 4'h4, 4'h4, 64'h77,      F,     F,     F,     F,     64'h0,       64'h0};
        vecs[14] = '{4'hE, 4'h4, 4'h4, 64'h77,      F,     F,     F,     F,     64'h0,       64'h0};
        vecs[15] = '{4'hF, 4'h4, 4'h4, 64'h77,      F,     F,     F,     F,     64'h0,       64'h0};

        rst_n = 1'b0;
        set_d(4'h1, F, F);
        D_ifun = 0; D_valC = 0; D_valP = 0;
        clear_fwd();
        model_reset();
        tick();
        tick();
        #2 rst_n = 1'b1;   // release between edges

        // Decode table under reset state.
        for (int i = 0; i < 16; i++) begin
            set_d(vecs[i].icode, vecs[i].rA, vecs[i].rB);
            D_valP = vecs[i].valP;
            D_ifun = 4'(i);
            D_valC = 64'hC0DE_0000 + 64'(i);
            #1;
            check($sformatf("tbl%0d.srcA", i), 64'(d_srcA), 64'(vecs[i].srcA));
            check($sformatf("tbl%0d.srcB", i), 64'(d_srcB), 64'(vecs[i].srcB));
            check($sformatf("tbl%0d.dstE", i), 64'(d_dstE), 64'(vecs[i].dstE));
            check($sformatf("tbl%0d.dstM", i), 64'(d_dstM), 64'(vecs[i].dstM));
            check($sformatf("tbl%0d.valA", i), d_valA, vecs[i].valA);
            check($sformatf("tbl%0d.valB", i), d_valB, vecs[i].valB);
            check($sformatf("tbl%0d.ifun", i), 64'(d_ifun), 64'(i));
            check($sformatf("tbl%0d.valC", i), d_valC, 64'hC0DE_0000 + 64'(i));
        end

        // Register-file write through the E port, then read from the file.
        tick();
        W_dstE = 4'h3; W_valE = 64'h55;
        tick();
        clear_fwd();
        set_d(4'h6, 4'h3, 4'h3);
        #1;
        check("wr3.valA", d_valA, 64'h55);
        check("wr3.valB", d_valB, 64'h55);

        // Forwarding priority e > M > W on dstE.
        e_dstE = 4'h1; M_dstE = 4'h1; W_dstE = 4'h1;
        e_valE = 64'd11; M_valE = 64'd22; W_valE = 64'd33;
        set_d(4'h6, 4'h1, F);
        #1 check("fwd.e", d_valA, 64'd11);
        e_dstE = F;
        #1 check("fwd.M", d_valA, 64'd22);
        M_dstE = F;
        #1 check("fwd.W", d_valA, 64'd33);
        tick();   // commits reg1 = 33

        // call: valA is valP, valB forwarded from execute.
        clear_fwd();
        e_dstE = 4'h4; e_valE = 64'hE4E4;
        set_d(4'h8, F, F);
        D_valP = 64'h2000;
        #1;
        check("call.valA", d_valA, 64'h2000);
        check("call.valB", d_valB, 64'hE4E4);

        // RNONE source ignores a stage that also names RNONE.
        clear_fwd();
        e_valE = 64'hDEAD; W_valM = 64'hBEEF;
        set_d(4'h2, F, F);
        #1 check("rnone.valA", d_valA, 64'h0);

        // Both write ports hit reg4 on the same edge: M port wins.
        clear_fwd();
        W_dstE = 4'h4; W_valE = 64'd7; W_dstM = 4'h4; W_valM = 64'd9;
        tick();
        clear_fwd();
        set_d(4'h6, 4'h4, 4'h1);
        #1;
        check("collide.reg4", d_valA, 64'd9);
        check("persist.reg1", d_valB, 64'd33);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 400; it++) begin
            set_d(4'($urandom_range(0, 15)), rand_reg(), rand_reg());
            D_ifun = 4'($urandom_range(0, 15));
            D_valC = {$urandom, $urandom};
            D_valP = {$urandom, $urandom};
            e_dstE = rand_reg(); e_valE = {$urandom, $urandom};
            M_dstE = rand_reg(); M_valE = {$urandom, $urandom};
            M_dstM = rand_reg(); m_valM = {$urandom, $urandom};
            W_dstE = rand_reg(); W_valE = {$urandom, $urandom};
            W_dstM = rand_reg(); W_valM = {$urandom, $urandom};
            #1 check_model($sformatf("rnd%0d", it));
            tick();
        end

        // Reset asserted between edges while a write to reg5 is pending.
        clear_fwd();
        W_dstE = 4'h5; W_valE = 64'hAA;
        tick();   // reg5 = 0xAA committed
        W_valE = 64'hBB;
        rst_n = 1'b0;
        model_reset();
        set_d(4'h6, 4'h5, 4'h4);
        #1 check("rst.fwd_still_W", d_valA, 64'hBB);
        W_dstE = F;
        #1;
        check("rst.async_reg5", d_valA, 64'h0);
        check("rst.async_reg4", d_valB, SP_INIT);
        W_dstE = 4'h5;
        tick();   // edge with reset low must not write
        W_dstE = F;
        rst_n = 1'b1;
        #1;
        check("rst.reg5_after", d_valA, 64'h0);
        check("rst.reg4_after", d_valB, SP_INIT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Decode/write-back stage of the Y86-64 pipeline; consumes the fetch→decode pipeline register outputs (D_*).
- Holds the 15-entry 64-bit architectural register file.
- Generates source/destination register IDs and operands valA/valB, with forwarding from the execute, memory and write-back stages.
- Commits W-stage results to the register file on the clock edge.

Parameters:
- DATA_W, 64, operand/register width.
- SP_RESET, 64'h0, reset value of %rsp (reg 4); all other registers reset to 0.

Ports:
- clk  in  1  stage clock; all register-file writes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- D_icode  in  4  instruction code from decode pipeline register.
- D_ifun  in  4  function code (passed through as d_ifun).
- D_rA  in  4  register A field.
- D_rB  in  4  register B field.
- D_valC  in  64  constant (passed through as d_valC).
- D_valP  in  64  incremented PC.
- e_dstE  in  4  execute-stage destination E.
- e_valE  in  64  execute-stage ALU result.
- M_dstE  in  4  memory-stage destination E.
- M_valE  in  64  memory-stage valE.
- M_dstM  in  4  memory-stage destination M.
- m_valM  in  64  memory read data.
- W_dstE  in  4  write-back destination E.
- W_valE  in  64  write-back valE.
- W_dstM  in  4  write-back destination M.
- W_valM  in  64  write-back valM.
- d_srcA  out  4  source A register ID.
- d_srcB  out  4  source B register ID.
- d_dstE  out  4  destination E register ID.
- d_dstM  out  4  destination M register ID.
- d_valA  out  64  forwarded operand A.
- d_valB  out  64  forwarded operand B.
- d_ifun  out  4  D_ifun pass-through.
- d_valC  out  64  D_valC pass-through.

Behaviour:
- Register ID 4'hF = RNONE; RSP = 4'h4. Icodes: 2 rrmovq/cmov, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.
- d_srcA:
  - rA for icode 2, 4, 6, A.
  - RSP for 9, B.
  - Otherwise RNONE.
- d_srcB:
  - rB for 4, 5, 6.
  - RSP for 8, 9, A, B.
  - Otherwise RNONE.
- d_dstE:
  - rB for 2, 3, 6.
  - RSP for 8, 9, A, B.
  - Otherwise RNONE.
- d_dstM:
  - rA for 5, B.
  - Otherwise RNONE.
- All decode outputs are combinational from current inputs; no added latency.
- d_valA priority:
  - D_valP if icode is 7 or 8.
  - Else RNONE source → 0.
  - Else first match of srcA against: e_dstE→e_valE, M_dstM→m_valM, M_dstE→M_valE, W_dstM→W_valM, W_dstE→W_valE.
  - Else regfile[srcA].
- d_valB: same chain applied to srcB, without the valP case.
- Forwarding never matches on RNONE: a stage dstX of 4'hF is ignored even when src is 4'hF.
- Register file:
  - 15 × DATA_W flops.
  - Asynchronous reset: reg4 = SP_RESET, all others = 0, applied immediately on rst_n falling.
  - Read is combinational.
- Writes on posedge clk when rst_n high:
  - W_dstE != F → reg[W_dstE] <= W_valE.
  - W_dstM != F → reg[W_dstM] <= W_valM.
- Both write ports targeting the same register: the M port wins (popq %rsp semantics).
- Reset asserted mid-operation overrides any pending write; no write occurs on an edge while rst_n is low.
- Write and read of the same register in the same cycle: the reader obtains the new value through W forwarding, never the stale register-file value.
- Unknown icodes (0, 1, C–F): all IDs RNONE; valA = valB = 0.

Test Plan:
- Reset released with SP_RESET=64'h100; D_icode=A (pushq), rA=2 → srcA=2, srcB=4, dstE=4, valA=0, valB=64'h100.
- W_dstE=3, W_valE=64'h55 for one edge, then D=OPq rA=3 rB=3 → both valA and valB read 64'h55 from the register file.
- e_dstE=M_dstE=W_dstE=1 with e_valE=11, M_valE=22, W_valE=33; D=OPq rA=1 → valA=11. Drop e_dstE to F → 22. Also drop M_dstE to F → 33.
- D_icode=8 (call), D_valP=64'h2000, e_dstE=4 → valA=64'h2000, valB=e_valE.
- W_dstE=4, W_valE=7 and W_dstM=4, W_valM=9 on the same edge → reg4=9 afterwards.
- Assert rst_n low between edges while W_dstE=5 is pending → reg5 stays 0; d_valA for srcA=5 reads 0 once forwarding inputs are RNONE.
